hi_lo_unit: RTL and testbench

HI_LO_UNIT -- requirements
Module: HiLo_Unit

---
 rtl/hi_lo_unit_pkg.sv | 21 ++
 rtl/hi_lo_unit_if.sv | 23 ++
 rtl/hi_lo_unit_addsub32.sv | 25 ++
 rtl/hi_lo_unit.sv | 98 +++++++++
 tb/tb_hi_lo_unit.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/hi_lo_unit_pkg.sv
// Shared processor definitions: Hi/Lo operation codes, Hi/Lo FSM states, datapath width.
// The EX-stage decoder imports the same package, so both sides always agree on these encodings.
package hi_lo_unit_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [2:0] {
      HILO_NONE = 3'd0,
      HILO_MULT = 3'd1,
      HILO_MADD = 3'd2,
      HILO_MSUB = 3'd3,
      HILO_MTHI = 3'd4,
      HILO_MTLO = 3'd5
   } hilo_op_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACC_HI = 1'b1
   } hilo_state_e;

endpackage

// File: rtl/hi_lo_unit_if.sv
// EX-stage to Hi/Lo unit bus: operation request from the pipeline, and the committed Hi/Lo values plus busy back.
interface hi_lo_unit_if;
   import hi_lo_unit_pkg::*;

   logic                  op_valid;
   logic [2:0]            hilo_op;
   logic [2*DATA_W-1:0]   product;
   logic [DATA_W-1:0]     rs_data;
   logic                  busy;
   logic [DATA_W-1:0]     hi;
   logic [DATA_W-1:0]     lo;

   modport master (
      output op_valid, hilo_op, product, rs_data,
      input  busy, hi, lo
   );

   modport slave (
      input  op_valid, hilo_op, product, rs_data,
      output busy, hi, lo
   );

endinterface

// File: rtl/hi_lo_unit_addsub32.sv
// 32-bit adder/subtractor: sum = a + (sub ? ~b : b) + cin, with carry-out.
// For subtraction cout=1 means "no borrow", so it chains straight into the next word's cin.
module hi_lo_unit_addsub32
   import hi_lo_unit_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              sub,
   input  logic              cin,
   output logic [DATA_W-1:0] sum,
   output logic              cout
);

   logic [DATA_W-1:0] b_eff;
   logic [DATA_W:0]   total;

   always_comb begin
      b_eff = b ^ {DATA_W{sub}};
      total = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin};
   end

   assign sum  = total[DATA_W-1:0];
   assign cout = total[DATA_W];

endmodule

// File: rtl/hi_lo_unit.sv
// Hi/Lo register unit: MULT/MTHI/MTLO commit in one edge; MADD/MSUB split the 64-bit
// accumulate over two edges, sharing one 32-bit adder between the Lo and Hi halves.
module hi_lo_unit
   import hi_lo_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   hi_lo_unit_if.slave bus
);

   hilo_state_e       state;
   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;
   logic [DATA_W-1:0] lo_tmp;
   logic [DATA_W-1:0] prod_hi_q;
   logic              carry_q;
   logic              acc_sub_q;

   logic [DATA_W-1:0] as_a;
   logic [DATA_W-1:0] as_b;
   logic [DATA_W-1:0] as_sum;
   logic              as_sub;
   logic              as_cin;
   logic              as_cout;
   logic              op_is_msub;

   // Adder serves the Lo half in IDLE and the Hi half (with the saved carry) in ACC_HI.
   always_comb begin
      op_is_msub = (bus.hilo_op == HILO_MSUB);
      if (state == ST_ACC_HI) begin
         as_a   = hi_q;
         as_b   = prod_hi_q;
         as_sub = acc_sub_q;
         as_cin = carry_q;
      end else begin
         as_a   = lo_q;
         as_b   = bus.product[DATA_W-1:0];
         as_sub = op_is_msub;
         as_cin = op_is_msub;
      end
   end

   hi_lo_unit_addsub32 u_addsub (
      .a    (as_a),
      .b    (as_b),
      .sub  (as_sub),
      .cin  (as_cin),
      .sum  (as_sum),
      .cout (as_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         hi_q      <= '0;
         lo_q      <= '0;
         lo_tmp    <= '0;
         prod_hi_q <= '0;
         carry_q   <= 1'b0;
         acc_sub_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.op_valid) begin
                  case (bus.hilo_op)
                     HILO_MULT: begin
                        hi_q <= bus.product[2*DATA_W-1:DATA_W];
                        lo_q <= bus.product[DATA_W-1:0];
                     end
                     HILO_MADD, HILO_MSUB: begin
                        lo_tmp    <= as_sum;
                        carry_q   <= as_cout;
                        prod_hi_q <= bus.product[2*DATA_W-1:DATA_W];
                        acc_sub_q <= op_is_msub;
                        state     <= ST_ACC_HI;
                     end
                     HILO_MTHI: hi_q <= bus.rs_data;
                     HILO_MTLO: lo_q <= bus.rs_data;
                     default: ;
                  endcase
               end
            end
            ST_ACC_HI: begin
               // Both halves land together so a half-updated pair is never visible.
               hi_q  <= as_sum;
               lo_q  <= lo_tmp;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy = (state == ST_ACC_HI);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hi_lo_unit.sv
// Bench for hi_lo_unit: directed corner cases plus randomized traffic against a 64-bit behavioural model.
module tb_hi_lo_unit;
   import hi_lo_unit_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   hi_lo_unit_if bus ();

   hi_lo_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model: architectural {hi,lo} plus a pending 64-bit accumulate result.
   logic [31:0] m_hi, m_lo;
   logic        m_pend;
   logic [63:0] m_res;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [63:0] p, input logic [31:0] rs);
      bus.op_valid = v;
      bus.hilo_op  = op;
      bus.product  = p;
      bus.rs_data  = rs;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".hi"},   {32'd0, bus.hi}, {32'd0, m_hi});
      chk({tag, ".lo"},   {32'd0, bus.lo}, {32'd0, m_lo});
      chk({tag, ".busy"}, {63'd0, bus.busy}, {63'd0, m_pend});
   endtask

   // One clock: predict from the inputs in place, clock, then compare.
   task automatic step(input string tag);
      logic [63:0] acc, n_acc, n_res;
      logic        n_pend;
      acc    = {m_hi, m_lo};
      n_acc  = acc;
      n_res  = m_res;
      n_pend = m_pend;
      if (m_pend) begin
         n_acc  = m_res;
         n_pend = 1'b0;
      end else if (bus.op_valid) begin
         case (bus.hilo_op)
            3'd1: n_acc = bus.product;
            3'd2: begin n_res = acc + bus.product; n_pend = 1'b1; end
            3'd3: begin n_res = acc - bus.product; n_pend = 1'b1; end
            3'd4: n_acc = {bus.rs_data, m_lo};
            3'd5: n_acc = {m_hi, bus.rs_data};
            default: ;
         endcase
      end
      @(posedge clk);
      #1;
      {m_hi, m_lo} = n_acc;
      m_res  = n_res;
      m_pend = n_pend;
      check_model(tag);
   endtask

   // Called about 1 time unit after a rising edge; finishes before the next one.
   task automatic async_reset(input string tag);
      rst_n = 1'b0;
      #1;
      m_hi = '0; m_lo = '0; m_pend = 1'b0; m_res = '0;
      check_model(tag);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      drive(1'b0, 3'd0, 64'd0, 32'd0);
      m_hi = '0; m_lo = '0; m_pend = 1'b0; m_res = '0;
      #1;
      check_model("reset");
      #1;
      rst_n = 1'b1;

      // MULT accepted on the very first edge after reset release
      drive(1'b1, HILO_MULT, 64'h00000001_FFFFFFFE, 32'd0);
      step("mult");
      chk("mult.hi_const", {32'd0, bus.hi}, 64'h1);
      chk("mult.lo_const", {32'd0, bus.lo}, 64'hFFFFFFFE);
      drive(1'b0, HILO_NONE, 64'd0, 32'd0);
      step("mult.after");
      chk("mult.busy_never", {63'd0, bus.busy}, 64'd0);

      // Back-to-back moves
      drive(1'b1, HILO_MTHI, 64'd0, 32'hDEADBEEF);
      step("mthi");
      chk("mthi.hi_const", {32'd0, bus.hi}, 64'hDEADBEEF);
      drive(1'b1, HILO_MTLO, 64'd0, 32'h12345678);
      step("mtlo");
      chk("mtlo.lo_const", {32'd0, bus.lo}, 64'h12345678);
      chk("mtlo.hi_kept",  {32'd0, bus.hi}, 64'hDEADBEEF);

      // MADD carry out of Lo into Hi
      drive(1'b1, HILO_MTHI, 64'd0, 32'h0);
      step("madd.setup_hi");
      drive(1'b1, HILO_MTLO, 64'd0, 32'hFFFFFFFF);
      step("madd.setup_lo");
      drive(1'b1, HILO_MADD, 64'd1, 32'd0);
      step("madd.e1");
      chk("madd.e1_busy", {63'd0, bus.busy}, 64'd1);
      chk("madd.e1_hi",   {32'd0, bus.hi}, 64'h0);
      chk("madd.e1_lo",   {32'd0, bus.lo}, 64'hFFFFFFFF);
      drive(1'b0, HILO_NONE, 64'd0, 32'd0);
      step("madd.e2");
      chk("madd.e2_hi",   {32'd0, bus.hi}, 64'h1);
      chk("madd.e2_lo",   {32'd0, bus.lo}, 64'h0);
      chk("madd.e2_busy", {63'd0, bus.busy}, 64'd0);

      // MSUB borrow out of Lo into Hi; MTHI during busy is dropped
      drive(1'b1, HILO_MSUB, 64'd1, 32'd0);
      step("msub.e1");
      chk("msub.e1_busy", {63'd0, bus.busy}, 64'd1);
      drive(1'b1, HILO_MTHI, 64'd0, 32'hDEADBEEF);
      step("msub.e2");
      chk("msub.e2_hi", {32'd0, bus.hi}, 64'h0);
      chk("msub.e2_lo", {32'd0, bus.lo}, 64'hFFFFFFFF);
      drive(1'b0, HILO_NONE, 64'd0, 32'd0);
      step("msub.after");
      chk("msub.after_hi", {32'd0, bus.hi}, 64'h0);

      // Reserved ops leave state alone
      drive(1'b1, 3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFFFFFF);
      step("op6");
      drive(1'b1, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFFFFFF);
      step("op7");

      // Reset during ACC_HI aborts the accumulate
      drive(1'b1, HILO_MTHI, 64'd0, 32'd5);
      step("abort.setup_hi");
      drive(1'b1, HILO_MTLO, 64'd0, 32'd7);
      step("abort.setup_lo");
      drive(1'b1, HILO_MADD, 64'h1234_5678_9ABC_DEF0, 32'd0);
      step("abort.e1");
      drive(1'b0, HILO_NONE, 64'd0, 32'd0);
      async_reset("abort.rst");
      step("abort.after");
      chk("abort.hi_const", {32'd0, bus.hi}, 64'h0);
      chk("abort.lo_const", {32'd0, bus.lo}, 64'h0);

      // Randomized traffic, with occasional asynchronous resets
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
               {$urandom, $urandom}, $urandom);
         step("rand");
         if ($urandom_range(0, 49) == 0) async_reset("rand.rst");
      end

      async_reset("final.rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
